// File: rtl/vga_timing_ctrl.sv
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA scan timing generator with internal pixel-rate enable and
//               frame-aligned start/stop handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_ctrl #(
  parameter int   CLK_DIV   = 4,
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             busy,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] C_DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] C_HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] C_HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] C_VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] C_VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [DIV_W-1:0]   w_div_nx;
  logic [CNT_W-1:0]   w_x_nx;
  logic [CNT_W-1:0]   w_y_nx;
  logic               w_ls_nx;
  logic               w_fs_nx;
  logic               w_busy_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state and next-counter values; every output register decodes these
  // so the outputs line up with x/y without an extra pipeline stage.
  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div_cnt;
    w_x_nx     = x;
    w_y_nx     = y;
    w_ls_nx    = 1'b0;
    w_fs_nx    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_nx = '0;
        if (en) begin
          w_state_nx = S_RUN;
          w_x_nx     = '0;
          w_y_nx     = '0;
          w_ls_nx    = 1'b1;
          w_fs_nx    = 1'b1;
        end
      end
      default: begin
        w_div_nx   = (r_div_cnt == C_DIV_MAX) ? '0 : r_div_cnt + 1'b1;
        w_state_nx = en ? S_RUN : S_DRAIN;
        if (pix_tick) begin
          if (x == C_X_LAST) begin
            w_x_nx  = '0;
            w_ls_nx = 1'b1;
            if (y == C_Y_LAST) begin
              w_y_nx  = '0;
              w_fs_nx = 1'b1;
              // A pending stop lands exactly on the frame boundary.
              if (r_state == S_DRAIN && !en) begin
                w_state_nx = S_IDLE;
                w_div_nx   = '0;
                w_ls_nx    = 1'b0;
                w_fs_nx    = 1'b0;
              end
            end else begin
              w_y_nx = y + 1'b1;
            end
          end else begin
            w_x_nx = x + 1'b1;
          end
        end
      end
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt   <= '0;
      x           <= '0;
      y           <= '0;
      busy        <= 1'b0;
      pix_tick    <= 1'b0;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
    end else begin
      r_div_cnt   <= w_div_nx;
      x           <= w_x_nx;
      y           <= w_y_nx;
      busy        <= w_busy_nx;
      pix_tick    <= w_busy_nx && (w_div_nx == C_DIV_MAX);
      video_on    <= w_busy_nx && (w_x_nx < C_H_ACT) && (w_y_nx < C_V_ACT);
      line_start  <= w_ls_nx;
      frame_start <= w_fs_nx;
      hsync       <= (w_busy_nx && w_x_nx >= C_HS_FIRST && w_x_nx <= C_HS_LAST)
                     ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (w_busy_nx && w_y_nx >= C_VS_FIRST && w_y_nx <= C_VS_LAST)
                     ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// ============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Bench for vga_timing_ctrl on a reduced geometry, two lanes
//               (CLK_DIV=4 and CLK_DIV=1) sharing clk/rst/en.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_ctrl;

  // Reduced geometry: 30 pixels x 15 lines keeps whole frames short.
  localparam int HA = 16, HFP = 4, HSW = 6, HBP = 4;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int CW = 5;
  localparam int VW = 7 + 2 * CW;
  localparam int B_BUSY = VW - 1, B_PIX = VW - 2, B_HS = VW - 3, B_VS = VW - 4;
  localparam int B_VON = VW - 5, B_LS = VW - 6, B_FS = VW - 7;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  logic [VW-1:0] d_vec [2];
  logic [VW-1:0] e_vec [2];

  for (genvar k = 0; k < 2; k++) begin : g_lane
    localparam int DIV   = (k == 0) ? 4 : 1;
    localparam int LINE  = DIV * HT;
    localparam int FRAME = LINE * VT;

    logic          busy, pix, hs, vs, von, ls, fs;
    logic [CW-1:0] dx, dy;

    vga_timing_ctrl #(
      .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .busy(busy), .pix_tick(pix),
      .hsync(hs), .vsync(vs), .video_on(von), .x(dx), .y(dy),
      .line_start(ls), .frame_start(fs)
    );

    // Model: clocks elapsed since frame origin, modulo one frame.
    int   m_t;
    logic m_busy, m_drain;
    int   ex, ey;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_busy  <= 1'b0;
        m_drain <= 1'b0;
        m_t     <= 0;
      end else if (!m_busy) begin
        if (en) begin
          m_busy  <= 1'b1;
          m_drain <= 1'b0;
          m_t     <= 0;
        end
      end else if (m_drain && !en && m_t == FRAME - 1) begin
        m_busy <= 1'b0;
        m_t    <= 0;
      end else begin
        m_t     <= (m_t + 1) % FRAME;
        m_drain <= !en;
      end
    end

    assign ex = (m_t / DIV) % HT;
    assign ey = (m_t / DIV) / HT;
    assign e_vec[k] = m_busy ?
      {1'b1, (m_t % DIV == DIV - 1),
       !(ex >= HA + HFP && ex < HA + HFP + HSW),
       !(ey >= VA + VFP && ey < VA + VFP + VSW),
       (ex < HA && ey < VA), (m_t % LINE == 0), (m_t == 0),
       CW'(ex), CW'(ey)}
      : {1'b0, 1'b0, 1'b1, 1'b1, 3'b000, {(2 * CW){1'b0}}};
    assign d_vec[k] = {busy, pix, hs, vs, von, ls, fs, dx, dy};
  end

  wire          busy0 = d_vec[0][B_BUSY];
  wire          pix0  = d_vec[0][B_PIX];
  wire          hs0   = d_vec[0][B_HS];
  wire          vs0   = d_vec[0][B_VS];
  wire          von0  = d_vec[0][B_VON];
  wire          ls0   = d_vec[0][B_LS];
  wire          fs0   = d_vec[0][B_FS];
  wire [CW-1:0] x0    = d_vec[0][2*CW-1:CW];
  wire [CW-1:0] y0    = d_vec[0][CW-1:0];
  wire          pix1  = d_vec[1][B_PIX];
  wire [CW-1:0] x1    = d_vec[1][2*CW-1:CW];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-lane hand-computed periods: line/frame in clks, hsync width in clks.
  int line_lit  [2] = '{120, 30};
  int frame_lit [2] = '{1800, 450};
  int hsw_lit   [2] = '{24, 6};
  int last_ls [2] = '{-1, -1};
  int last_fs [2] = '{-1, -1};
  int hs_run  [2] = '{0, 0};

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("lane%0d outputs", k), int'(d_vec[k]), int'(e_vec[k]));
      if (!d_vec[k][B_BUSY]) begin
        last_ls[k] = -1;
        last_fs[k] = -1;
        hs_run[k]  = 0;
      end else begin
        if (d_vec[k][B_LS]) begin
          if (last_ls[k] >= 0) chk($sformatf("lane%0d line period", k), cyc - last_ls[k], line_lit[k]);
          last_ls[k] = cyc;
        end
        if (d_vec[k][B_FS]) begin
          if (last_fs[k] >= 0) chk($sformatf("lane%0d frame period", k), cyc - last_fs[k], frame_lit[k]);
          last_fs[k] = cyc;
        end
        if (!d_vec[k][B_HS]) hs_run[k]++;
        else if (hs_run[k] > 0) begin
          chk($sformatf("lane%0d hsync width", k), hs_run[k], hsw_lit[k]);
          hs_run[k] = 0;
        end
      end
    end
  end

  task automatic wait_xy(input int wx, input int wy);
    int n;
    n = 0;
    while (!(busy0 && x0 == CW'(wx) && y0 == CW'(wy)) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) chk($sformatf("wait for (%0d,%0d) timeout", wx, wy), 1, 0);
  endtask

  initial begin
    int px, py, n;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy0, 0);
    chk("reset x", x0, 0);
    chk("reset hsync", hs0, 1);
    chk("reset vsync", vs0, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle busy", busy0, 0);

    // Start: pulses one clk after en is sampled, x=1 after CLK_DIV clks.
    en = 1'b1;
    @(negedge clk);
    chk("start frame_start", fs0, 1);
    chk("start line_start", ls0, 1);
    chk("start busy", busy0, 1);
    chk("div1 pix_tick", pix1, 1);
    @(negedge clk);
    chk("div1 x after 1", x1, 1);
    chk("div4 pix_tick early", pix0, 0);
    repeat (2) @(negedge clk);
    chk("div4 pix_tick", pix0, 1);
    chk("div4 x before tick", x0, 0);
    @(negedge clk);
    chk("div4 x after 4", x0, 1);

    // Decode boundaries.
    wait_xy(19, 0);
    chk("x19 hsync", hs0, 1);
    chk("x19 video_on", von0, 0);
    wait_xy(20, 0);
    chk("x20 hsync", hs0, 0);
    wait_xy(15, 7);
    chk("x15y7 video_on", von0, 1);
    wait_xy(0, 8);
    chk("y8 video_on", von0, 0);
    wait_xy(0, 9);
    chk("y9 vsync", vs0, 1);
    wait_xy(0, 10);
    chk("y10 vsync", vs0, 0);
    wait_xy(0, 12);
    chk("y12 vsync", vs0, 1);
    repeat (3700) @(negedge clk);

    // Stop request mid-frame drains to the frame boundary.
    wait_xy(10, 5);
    en = 1'b0;
    px = 0; py = 0; n = 0;
    while (busy0 && n < 4000) begin
      px = int'(x0);
      py = int'(y0);
      @(negedge clk);
      n++;
    end
    chk("drain timeout", int'(n >= 4000), 0);
    chk("drain last x", px, HT - 1);
    chk("drain last y", py, VT - 1);
    chk("drain idle x", x0, 0);
    chk("drain idle hsync", hs0, 1);
    chk("drain idle vsync", vs0, 1);
    chk("drain no frame_start", fs0, 0);

    // Re-raising en before the wrap keeps scanning continuous.
    en = 1'b1;
    @(negedge clk);
    chk("restart frame_start", fs0, 1);
    wait_xy(10, 5);
    en = 1'b0;
    wait_xy(0, 13);
    en = 1'b1;
    wait_xy(0, 0);
    chk("rerun busy", busy0, 1);
    chk("rerun frame_start", fs0, 1);

    // Asynchronous reset mid-frame.
    wait_xy(12, 4);
    #1 rst = 1'b1;
    #1;
    chk("async rst busy", busy0, 0);
    chk("async rst x", x0, 0);
    chk("async rst y", y0, 0);
    chk("async rst pix_tick", pix0, 0);
    chk("async rst hsync", hs0, 1);
    chk("async rst video_on", von0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst frame_start", fs0, 1);
    chk("post rst x", x0, 0);
    chk("post rst y", y0, 0);
    repeat (300) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
